// File: rtl/ram32x2_ctl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram32x2_ctl_pkg                                               |
// | Purpose  : Shared types and constants for the 32x2 bipolar RAM           |
// |            controller: geometry, port-select codes, FSM state encoding.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ram32x2_ctl_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 2;
  localparam int WORDS  = 32;

  // Port-select codes used by the arbiter's last-grant register and by the
  // operand register that remembers who owns the in-flight access.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [3:0] {
    ST_INIT_SETUP = 4'd0,
    ST_INIT_PULSE = 4'd1,
    ST_INIT_HOLD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_RD_SETUP   = 4'd4,
    ST_RD_LATCH   = 4'd5,
    ST_WR_SETUP   = 4'd6,
    ST_WR_PULSE   = 4'd7,
    ST_WR_HOLD    = 4'd8,
    ST_ACK        = 4'd9
  } state_e;

endpackage : ram32x2_ctl_pkg
`default_nettype wire

// File: rtl/ram32x2_ctl_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb2                                                       |
// | Purpose  : Two-requester round-robin arbiter. Grants are combinational   |
// |            from req/en; the last-grant register only moves on a real     |
// |            grant, so a tie goes to the port not served last.             |
// | Ports    : clk, rst_n   - clock, async active-low reset                  |
// |            en           - arbitration enabled (controller in IDLE)       |
// |            req_a, req_b - requests                                       |
// |            gnt_a, gnt_b - one-hot (or zero) grant                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb2
  import ram32x2_ctl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_a  = en & req_a & (~req_b | (last_q == PORT_B));
    gnt_b  = en & req_b & (~req_a | (last_q == PORT_A));
    last_d = last_q;
    if (gnt_a) begin
      last_d = PORT_A;
    end else if (gnt_b) begin
      last_d = PORT_B;
    end
  end

  // Resetting to B hands the first tie to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram32x2_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram32x2_ctl                                                   |
// | Purpose  : Sequencer/arbiter for one 32x2 latched bipolar RAM. Zero-     |
// |            fills the part after reset, then serves port A and port B     |
// |            round-robin. Every RAM strobe comes straight from a flop.     |
// | Ports    : clk, reset_n          - clock, async active-low reset         |
// |            {a,b}_req/we/addr/wdata/wmask - request side, held to ack     |
// |            {a,b}_ack, {a,b}_rdata        - completion pulse, read data   |
// |            init_busy             - sweep in progress                     |
// |            ram_a, ram_i, ram_ce, ram_latch_n, ram_wclk_n,                |
// |            ram_we0_n, ram_we1_n  - RAM pins (outputs)                    |
// |            ram_d                 - RAM data outputs                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram32x2_ctl
  import ram32x2_ctl_pkg::*;
#(
  parameter logic [1:0] INIT_VALUE    = 2'b00,
  parameter bit         INIT_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [4:0] a_addr,
  input  logic [1:0] a_wdata,
  input  logic [1:0] a_wmask,
  output logic       a_ack,
  output logic [1:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [4:0] b_addr,
  input  logic [1:0] b_wdata,
  input  logic [1:0] b_wmask,
  output logic       b_ack,
  output logic [1:0] b_rdata,
  output logic       init_busy,
  output logic [4:0] ram_a,
  output logic [1:0] ram_i,
  output logic       ram_ce,
  output logic       ram_latch_n,
  output logic       ram_wclk_n,
  output logic       ram_we0_n,
  output logic       ram_we1_n,
  input  logic [1:0] ram_d
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              op_port_q, op_port_d;
  logic [1:0]        op_wmask_q, op_wmask_d;
  logic              init_busy_q, init_busy_d;
  logic [4:0]        ram_a_q, ram_a_d;
  logic [1:0]        ram_i_q, ram_i_d;
  logic              ce_q, ce_d;
  logic              latch_n_q, latch_n_d;
  logic              wclk_n_q, wclk_n_d;
  logic              we0_n_q, we0_n_d;
  logic              we1_n_q, we1_n_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [1:0]        a_rdata_q, a_rdata_d;
  logic [1:0]        b_rdata_q, b_rdata_d;

  logic arb_en;
  logic gnt_a;
  logic gnt_b;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (arb_en),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Strobe flops are loaded with the value belonging to the state being
  // entered, so each strobe is aligned with its state and glitch-free.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_port_d   = op_port_q;
    op_wmask_d  = op_wmask_q;
    init_busy_d = init_busy_q;
    ram_a_d     = ram_a_q;
    ram_i_d     = ram_i_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    ce_d        = 1'b0;
    latch_n_d   = 1'b1;
    wclk_n_d    = 1'b1;
    we0_n_d     = 1'b1;
    we1_n_d     = 1'b1;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    arb_en      = 1'b0;

    unique case (state_q)
      ST_INIT_SETUP: begin
        state_d  = ST_INIT_PULSE;
        ce_d     = 1'b1;
        wclk_n_d = 1'b0;
        we0_n_d  = 1'b0;
        we1_n_d  = 1'b0;
        // ram_i leaves reset at 0; for a non-zero fill word, address 0 picks
        // up INIT_VALUE here, later words already carry it from SETUP entry.
        ram_i_d  = INIT_VALUE;
      end
      ST_INIT_PULSE: begin
        state_d = ST_INIT_HOLD;
        ce_d    = 1'b1;
      end
      ST_INIT_HOLD: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_busy_d = 1'b0;
        end else begin
          state_d = ST_INIT_SETUP;
          cnt_d   = cnt_q + 1'b1;
          ram_a_d = cnt_q + 1'b1;
          ram_i_d = INIT_VALUE;
          ce_d    = 1'b1;
        end
      end
      ST_IDLE: begin
        arb_en = 1'b1;
        if (gnt_a || gnt_b) begin
          // Operands are captured once here; the requester may change its
          // fields afterwards without disturbing the access.
          op_port_d  = gnt_b ? PORT_B : PORT_A;
          op_wmask_d = gnt_b ? b_wmask : a_wmask;
          ram_a_d    = gnt_b ? b_addr : a_addr;
          ce_d       = 1'b1;
          if (gnt_b ? b_we : a_we) begin
            state_d = ST_WR_SETUP;
            ram_i_d = gnt_b ? b_wdata : a_wdata;
          end else begin
            state_d = ST_RD_SETUP;
          end
        end
      end
      ST_RD_SETUP: begin
        state_d   = ST_RD_LATCH;
        ce_d      = 1'b1;
        latch_n_d = 1'b0;
      end
      ST_RD_LATCH: begin
        state_d = ST_ACK;
        if (op_port_q == PORT_B) begin
          b_rdata_d = ram_d;
          b_ack_d   = 1'b1;
        end else begin
          a_rdata_d = ram_d;
          a_ack_d   = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        ce_d     = 1'b1;
        wclk_n_d = 1'b0;
        we0_n_d  = ~op_wmask_q[0];
        we1_n_d  = ~op_wmask_q[1];
      end
      ST_WR_PULSE: begin
        state_d = ST_WR_HOLD;
        ce_d    = 1'b1;
      end
      ST_WR_HOLD: begin
        state_d = ST_ACK;
        a_ack_d = (op_port_q == PORT_A);
        b_ack_d = (op_port_q == PORT_B);
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT_ON_RESET ? ST_INIT_SETUP : ST_IDLE;
      cnt_q       <= '0;
      op_port_q   <= PORT_A;
      op_wmask_q  <= 2'b00;
      init_busy_q <= INIT_ON_RESET;
      ram_a_q     <= '0;
      ram_i_q     <= 2'b00;
      ce_q        <= 1'b0;
      latch_n_q   <= 1'b1;
      wclk_n_q    <= 1'b1;
      we0_n_q     <= 1'b1;
      we1_n_q     <= 1'b1;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= 2'b00;
      b_rdata_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_port_q   <= op_port_d;
      op_wmask_q  <= op_wmask_d;
      init_busy_q <= init_busy_d;
      ram_a_q     <= ram_a_d;
      ram_i_q     <= ram_i_d;
      ce_q        <= ce_d;
      latch_n_q   <= latch_n_d;
      wclk_n_q    <= wclk_n_d;
      we0_n_q     <= we0_n_d;
      we1_n_q     <= we1_n_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign init_busy   = init_busy_q;
  assign ram_a       = ram_a_q;
  assign ram_i       = ram_i_q;
  assign ram_ce      = ce_q;
  assign ram_latch_n = latch_n_q;
  assign ram_wclk_n  = wclk_n_q;
  assign ram_we0_n   = we0_n_q;
  assign ram_we1_n   = we1_n_q;

endmodule : ram32x2_ctl
`default_nettype wire

// File: tb/tb_ram32x2_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram32x2_ctl                                                |
// | Purpose  : Directed self-checking bench for ram32x2_ctl with a small     |
// |            behavioural model of the 32x2 RAM.                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram32x2_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [1:0] a_wdata, a_wmask, b_wdata, b_wmask;
  logic       a_ack, b_ack, init_busy;
  logic [1:0] a_rdata, b_rdata;
  logic [4:0] ram_a;
  logic [1:0] ram_i, ram_d;
  logic       ram_ce, ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n;

  int total = 0;
  int bad   = 0;

  logic [1:0] mem [32];
  int         pulse_cnt, addr_err, data_err;
  logic [4:0] sweep_addr;
  bit         we0_seen, we1_seen, both_ack, init_ack;

  always #5 clk = ~clk;

  ram32x2_ctl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_wmask     (a_wmask),
    .a_ack       (a_ack),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_wmask     (b_wmask),
    .b_ack       (b_ack),
    .b_rdata     (b_rdata),
    .init_busy   (init_busy),
    .ram_a       (ram_a),
    .ram_i       (ram_i),
    .ram_ce      (ram_ce),
    .ram_latch_n (ram_latch_n),
    .ram_wclk_n  (ram_wclk_n),
    .ram_we0_n   (ram_we0_n),
    .ram_we1_n   (ram_we1_n),
    .ram_d       (ram_d)
  );

  // RAM model: address is stable through a read, so output follows the array.
  assign ram_d = mem[ram_a];

  // Mid-cycle observation of the part strobes; writes land here too.
  always @(negedge clk) begin
    if (!ram_wclk_n) begin
      if (init_busy) begin
        if (ram_a !== sweep_addr) addr_err++;
        if (ram_i !== 2'b00) data_err++;
        sweep_addr++;
        pulse_cnt++;
      end
      if (!ram_we0_n) mem[ram_a][0] = ram_i[0];
      if (!ram_we1_n) mem[ram_a][1] = ram_i[1];
    end
    if (!ram_we0_n) we0_seen = 1'b1;
    if (!ram_we1_n) we1_seen = 1'b1;
    if (a_ack && b_ack) both_ack = 1'b1;
    if ((a_ack || b_ack) && init_busy) init_ack = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its ack; lat = edges from req to ack.
  task automatic access(input bit port, input bit we, input logic [4:0] addr,
                        input logic [1:0] wd, input logic [1:0] wm,
                        output int lat, output logic [1:0] rd);
    if (port) begin
      b_we = we; b_addr = addr; b_wdata = wd; b_wmask = wm; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wd; a_wmask = wm; a_req = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(port ? b_ack : a_ack) && lat < 50);
    rd    = port ? b_rdata : a_rdata;
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wmask = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wmask = 0;
    repeat (3) tick();
    total++;
    if ({ram_a, ram_i, ram_ce} !== 8'h00) begin
      bad++; $display("FAIL reset_addr_data: got a=%0d i=%b ce=%b want 0/00/0", ram_a, ram_i, ram_ce);
    end
    total++;
    if ({ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n} !== 4'b1111) begin
      bad++; $display("FAIL reset_strobes: got %b want 1111", {ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n});
    end
    total++;
    if ({a_ack, b_ack, a_rdata, b_rdata, init_busy} !== 7'b0000001) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000001", {a_ack, b_ack, a_rdata, b_rdata, init_busy});
    end
  endtask

  task automatic test_sweep;
    int n;
    int nz;
    for (int i = 0; i < 32; i++) mem[i] = 2'b11;
    pulse_cnt = 0; addr_err = 0; data_err = 0; sweep_addr = '0; init_ack = 0;
    reset_n = 1'b1;
    n = 0;
    while (init_busy && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n !== 96) begin
      bad++; $display("FAIL sweep_length: init_busy fell after %0d edges want 96", n);
    end
    total++;
    if (pulse_cnt !== 32 || addr_err !== 0 || data_err !== 0) begin
      bad++; $display("FAIL sweep_pulses: pulses=%0d addr_err=%0d data_err=%0d want 32/0/0", pulse_cnt, addr_err, data_err);
    end
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== 2'b00) nz++;
    total++;
    if (nz !== 0) begin
      bad++; $display("FAIL sweep_contents: %0d nonzero words want 0", nz);
    end
  endtask

  task automatic test_write_read;
    int lat;
    logic [1:0] rd;
    access(1'b0, 1'b1, 5'd5, 2'b10, 2'b11, lat, rd);
    total++;
    if (lat !== 4 || mem[5] !== 2'b10) begin
      bad++; $display("FAIL a_write: lat=%0d mem=%b want 4/10", lat, mem[5]);
    end
    access(1'b0, 1'b0, 5'd5, 2'b00, 2'b00, lat, rd);
    total++;
    if (lat !== 3 || rd !== 2'b10) begin
      bad++; $display("FAIL a_read: lat=%0d rdata=%b want 3/10", lat, rd);
    end
    total++;
    if (a_rdata !== 2'b10 || b_rdata !== 2'b00) begin
      bad++; $display("FAIL rdata_hold: a=%b b=%b want 10/00", a_rdata, b_rdata);
    end
  endtask

  task automatic test_masked_write;
    int lat;
    logic [1:0] rd;
    access(1'b0, 1'b1, 5'd7, 2'b11, 2'b11, lat, rd);
    we0_seen = 0; we1_seen = 0;
    access(1'b0, 1'b1, 5'd7, 2'b00, 2'b01, lat, rd);
    total++;
    if (we1_seen !== 1'b0 || we0_seen !== 1'b1) begin
      bad++; $display("FAIL mask01_strobes: we0_seen=%b we1_seen=%b want 1/0", we0_seen, we1_seen);
    end
    access(1'b0, 1'b0, 5'd7, 2'b00, 2'b00, lat, rd);
    total++;
    if (rd !== 2'b10) begin
      bad++; $display("FAIL mask01_read: rdata=%b want 10", rd);
    end
    we0_seen = 0; we1_seen = 0;
    access(1'b1, 1'b1, 5'd7, 2'b01, 2'b00, lat, rd);
    total++;
    if (lat !== 4 || we0_seen || we1_seen || mem[7] !== 2'b10) begin
      bad++; $display("FAIL mask00_write: lat=%0d we0=%b we1=%b mem=%b want 4/0/0/10", lat, we0_seen, we1_seen, mem[7]);
    end
    access(1'b1, 1'b1, 5'd9, 2'b01, 2'b11, lat, rd);
  endtask

  task automatic test_back_to_back;
    int n;
    int k;
    bit ord [4];
    logic [1:0] ra [4];
    logic [1:0] rb [4];
    a_we = 0; a_addr = 5'd5; b_we = 0; b_addr = 5'd9;
    a_req = 1'b1; b_req = 1'b1; both_ack = 0;
    n = 0; k = 0;
    while (k < 4 && n < 80) begin
      tick();
      n++;
      if (a_ack || b_ack) begin
        ord[k] = b_ack;
        ra[k]  = a_rdata;
        rb[k]  = b_rdata;
        k++;
      end
      a_req = !a_ack;
      b_req = !b_ack;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) tick();
    total++;
    if (k !== 4 || both_ack) begin
      bad++; $display("FAIL rr_acks: acks=%0d both=%b want 4/0", k, both_ack);
    end
    total++;
    if ({ord[0], ord[1], ord[2], ord[3]} !== 4'b0101) begin
      bad++; $display("FAIL rr_order: got %b%b%b%b want 0101 (0=A)", ord[0], ord[1], ord[2], ord[3]);
    end
    total++;
    if ({ra[0], rb[0], ra[1], rb[1]} !== 8'b10_00_10_01) begin
      bad++; $display("FAIL rr_rdata_01: got %b %b %b %b want 10 00 10 01", ra[0], rb[0], ra[1], rb[1]);
    end
    total++;
    if ({ra[2], rb[2], ra[3], rb[3]} !== 8'b10_01_10_01) begin
      bad++; $display("FAIL rr_rdata_23: got %b %b %b %b want 10 01 10 01", ra[2], rb[2], ra[3], rb[3]);
    end
  endtask

  task automatic test_reset_mid_write;
    int n;
    int fall;
    bit a_seen;
    a_we = 1; a_addr = 5'd3; a_wdata = 2'b11; a_wmask = 2'b11; a_req = 1'b1;
    n = 0;
    while (ram_wclk_n && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (ram_wclk_n !== 1'b0) begin
      bad++; $display("FAIL midreset_reach_pulse: wclk_n=%b want 0", ram_wclk_n);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({ram_ce, ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, a_ack, init_busy, ram_a} !== 12'b0_1111_0_1_00000) begin
      bad++; $display("FAIL midreset_async: got %b want 011110100000",
                      {ram_ce, ram_latch_n, ram_wclk_n, ram_we0_n, ram_we1_n, a_ack, init_busy, ram_a});
    end
    a_req = 1'b0;
    b_we = 0; b_addr = 5'd9; b_req = 1'b1;
    pulse_cnt = 0; addr_err = 0; data_err = 0; sweep_addr = '0; init_ack = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    n = 0; fall = 0; a_seen = 0;
    while (!b_ack && n < 200) begin
      tick();
      n++;
      if (!init_busy && fall == 0) fall = n;
      if (a_ack) a_seen = 1'b1;
    end
    b_req = 1'b0;
    tick();
    total++;
    if (fall !== 96 || n !== 99) begin
      bad++; $display("FAIL midreset_timing: busy fell at %0d ack at %0d want 96/99", fall, n);
    end
    total++;
    if (pulse_cnt !== 32 || addr_err !== 0 || init_ack || a_seen) begin
      bad++; $display("FAIL midreset_sweep: pulses=%0d addr_err=%0d init_ack=%b a_ack=%b want 32/0/0/0",
                      pulse_cnt, addr_err, init_ack, a_seen);
    end
    total++;
    if (mem[3] !== 2'b00 || b_rdata !== 2'b00) begin
      bad++; $display("FAIL midreset_data: mem3=%b b_rdata=%b want 00/00", mem[3], b_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram32x2_ctl
`default_nettype wire
